// File: rtl/klotski_pkg.sv
// Shared types and constants for the board capture / validation path.
// Contents:
//   state_t    - sequencer states of board_stabilizer
//   BOARD_W    - width of a packed board (16 cells x 4-bit tiles)
//   CELLS      - number of cells on the board
//   TILE_W     - bits per tile
//   BLANK_TILE - tile value that marks the empty cell
//   cell_of()  - extracts cell k of a packed board (cell 0 in the top nibble)
package klotski_pkg;

  localparam int BOARD_W = 64;
  localparam int CELLS   = 16;
  localparam int TILE_W  = 4;

  localparam logic [TILE_W-1:0] BLANK_TILE = 4'h0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_CHECK   = 3'd3,
    S_COMPARE = 3'd4,
    S_PUBLISH = 3'd5
  } state_t;

  // Cell 0 (row 0, col 0) lives in the most significant nibble; row-major.
  function automatic logic [TILE_W-1:0] cell_of(input logic [BOARD_W-1:0] b,
                                                 input logic [3:0]         k);
    return b[(CELLS-1-int'(k))*TILE_W +: TILE_W];
  endfunction

endpackage

// File: rtl/board_perm_check.sv
// Walks the 16 nibbles of a board, one per cycle, to decide whether they form
// a permutation of 0..15 and where the blank tile sits.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - one-cycle pulse; clears the walk state, walking starts next cycle
//   board      - board under test; must stay stable for the 16 walk cycles
//   done       - high in the cycle the last nibble (cell 15) is examined
//   dup        - some tile value occurred twice (valid together with done)
//   blank_idx  - cell index holding BLANK_TILE (valid together with done)
// dup and blank_idx already include the nibble examined in the done cycle so
// the caller can move on in the very next cycle.
module board_perm_check
  import klotski_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BOARD_W-1:0] board,
  output logic               done,
  output logic               dup,
  output logic [3:0]         blank_idx
);

  localparam logic [3:0] LAST_CELL = 4'(CELLS - 1);

  logic             busy_q,  busy_d;
  logic [3:0]       k_q,     k_d;
  logic [CELLS-1:0] seen_q,  seen_d;
  logic             dup_q,   dup_d;
  logic [3:0]       blank_q, blank_d;
  logic [TILE_W-1:0] n;

  always_comb begin
    busy_d  = busy_q;
    k_d     = k_q;
    seen_d  = seen_q;
    dup_d   = dup_q;
    blank_d = blank_q;
    done    = 1'b0;
    n       = cell_of(board, k_q);

    if (start) begin
      busy_d  = 1'b1;
      k_d     = 4'd0;
      seen_d  = '0;
      dup_d   = 1'b0;
      blank_d = 4'd0;
    end else if (busy_q) begin
      if (seen_q[n]) dup_d = 1'b1;
      seen_d[n] = 1'b1;
      if (n == BLANK_TILE) blank_d = k_q;
      k_d = k_q + 4'd1;
      if (k_q == LAST_CELL) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end

    dup       = dup_d;
    blank_idx = blank_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      k_q     <= 4'd0;
      seen_q  <= '0;
      dup_q   <= 1'b0;
      blank_q <= 4'd0;
    end else begin
      busy_q  <= busy_d;
      k_q     <= k_d;
      seen_q  <= seen_d;
      dup_q   <= dup_d;
      blank_q <= blank_d;
    end
  end

endmodule

// File: rtl/board_stabilizer.sv
// Capture sequencer and validator sitting after the grid-sampling reader.
// It keeps triggering captures while enabled, checks each returned tile order
// is a permutation of 0..15, and publishes a board only after STABLE_COUNT
// consecutive identical valid captures that differ from the current output.
// Ports:
//   i_Clk, i_rst_n   - clock, asynchronous active-low reset
//   i_enable         - level; keep the capture loop running
//   o_capture_start  - one-cycle start pulse to the reader
//   i_capture_done   - reader done pulse (only honoured while waiting)
//   i_block_order    - reader result, cell 0 in [63:60], row-major
//   o_board          - last published board
//   o_blank_idx      - cell index of the blank tile in o_board
//   o_board_valid    - one-cycle pulse when o_board changes
//   o_reject_cnt     - saturating count of invalid / timed-out captures
//   o_dbg_state      - current sequencer state
// Handshake: the reader is started by a single-cycle o_capture_start and
// answers with a single-cycle i_capture_done carrying i_block_order; there is
// no backpressure, a missing answer is abandoned after TIMEOUT_CYC cycles.
module board_stabilizer
  import klotski_pkg::*;
#(
  parameter int STABLE_COUNT = 3,
  parameter int TIMEOUT_CYC  = 2_000_000
) (
  input  logic               i_Clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  output logic               o_capture_start,
  input  logic               i_capture_done,
  input  logic [BOARD_W-1:0] i_block_order,
  output logic [BOARD_W-1:0] o_board,
  output logic [3:0]         o_blank_idx,
  output logic               o_board_valid,
  output logic [7:0]         o_reject_cnt,
  output state_t             o_dbg_state
);

  localparam int         TO_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0] STABLE_MAX = 4'(STABLE_COUNT);

  state_t             state_q,      state_d;
  logic [TO_W-1:0]    to_q,         to_d;
  logic [BOARD_W-1:0] cap_q,        cap_d;
  logic [BOARD_W-1:0] cand_q,       cand_d;
  logic [3:0]         cand_blank_q, cand_blank_d;
  logic [3:0]         blank_cand_q, blank_cand_d;
  logic               dup_q,        dup_d;
  logic [3:0]         stable_q,     stable_d;
  logic               published_q,  published_d;
  logic [BOARD_W-1:0] board_q,      board_d;
  logic [3:0]         blank_idx_q,  blank_idx_d;
  logic               valid_q,      valid_d;
  logic               start_q,      start_d;
  logic [7:0]         rej_q,        rej_d;

  logic       chk_start;
  logic       chk_done;
  logic       chk_dup;
  logic [3:0] chk_blank;
  logic       reject;

  board_perm_check u_perm (
    .clk       (i_Clk),
    .rst_n     (i_rst_n),
    .start     (chk_start),
    .board     (cap_q),
    .done      (chk_done),
    .dup       (chk_dup),
    .blank_idx (chk_blank)
  );

  always_comb begin
    state_d      = state_q;
    to_d         = to_q;
    cap_d        = cap_q;
    cand_d       = cand_q;
    cand_blank_d = cand_blank_q;
    blank_cand_d = blank_cand_q;
    dup_d        = dup_q;
    stable_d     = stable_q;
    published_d  = published_q;
    board_d      = board_q;
    blank_idx_d  = blank_idx_q;
    valid_d      = 1'b0;
    rej_d        = rej_q;
    chk_start    = 1'b0;
    reject       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_START;
      end

      S_START: begin
        to_d    = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (i_capture_done) begin
          cap_d     = i_block_order;
          chk_start = 1'b1;
          state_d   = S_CHECK;
        end else if (to_q == TO_LAST) begin
          reject   = 1'b1;
          stable_d = 4'd0;
          state_d  = i_enable ? S_START : S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      S_CHECK: begin
        if (chk_done) begin
          dup_d        = chk_dup;
          blank_cand_d = chk_blank;
          state_d      = S_COMPARE;
        end
      end

      S_COMPARE: begin
        state_d = i_enable ? S_START : S_IDLE;
        if (dup_q) begin
          reject   = 1'b1;
          stable_d = 4'd0;
        end else begin
          // stable_q == 0 means the candidate was invalidated by a reject or
          // timeout, so even an identical capture restarts the run at 1.
          if (cap_q == cand_q && stable_q != 4'd0) begin
            if (stable_q != STABLE_MAX) stable_d = stable_q + 4'd1;
          end else begin
            cand_d       = cap_q;
            cand_blank_d = blank_cand_q;
            stable_d     = 4'd1;
          end
          // The output registers are loaded on entry to S_PUBLISH so the
          // new board and its valid pulse appear during the publish cycle.
          if (stable_d == STABLE_MAX && (cand_d != board_q || !published_q)) begin
            state_d     = S_PUBLISH;
            board_d     = cand_d;
            blank_idx_d = cand_blank_d;
            valid_d     = 1'b1;
            published_d = 1'b1;
          end
        end
      end

      S_PUBLISH: begin
        state_d = i_enable ? S_START : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (reject && rej_q != 8'hFF) rej_d = rej_q + 8'd1;

    // Registered start pulse: high exactly while the sequencer sits in S_START.
    start_d = (state_d == S_START);
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      to_q         <= '0;
      cap_q        <= '0;
      cand_q       <= '0;
      cand_blank_q <= 4'd0;
      blank_cand_q <= 4'd0;
      dup_q        <= 1'b0;
      stable_q     <= 4'd0;
      published_q  <= 1'b0;
      board_q      <= '0;
      blank_idx_q  <= 4'd0;
      valid_q      <= 1'b0;
      start_q      <= 1'b0;
      rej_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      to_q         <= to_d;
      cap_q        <= cap_d;
      cand_q       <= cand_d;
      cand_blank_q <= cand_blank_d;
      blank_cand_q <= blank_cand_d;
      dup_q        <= dup_d;
      stable_q     <= stable_d;
      published_q  <= published_d;
      board_q      <= board_d;
      blank_idx_q  <= blank_idx_d;
      valid_q      <= valid_d;
      start_q      <= start_d;
      rej_q        <= rej_d;
    end
  end

  assign o_capture_start = start_q;
  assign o_board         = board_q;
  assign o_blank_idx     = blank_idx_q;
  assign o_board_valid   = valid_q;
  assign o_reject_cnt    = rej_q;
  assign o_dbg_state     = state_q;

endmodule

// File: doc/board_stabilizer.md
# board_stabilizer

Sequencer and validator downstream of the grid-sampling reader. It repeatedly triggers a board capture, accepts the 64-bit tile order the reader returns, and checks that the 16 nibbles form a permutation of 0..15. It publishes a board to the solver only after STABLE_COUNT consecutive identical valid captures. It also reports the blank cell position and keeps a count of rejected captures.

## Interface
- STABLE_COUNT, 3: consecutive identical valid captures required to publish (1..15).
- TIMEOUT_CYC, 2_000_000: cycles to wait for done before abandoning a capture (about 3 frames of 1056×628).
- i_Clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_enable  in  1  level; run the continuous capture loop while high.
- o_capture_start  out  1  one-cycle pulse to the reader's start input.
- i_capture_done  in  1  reader done pulse.
- i_block_order  in  64  reader result; nibble [63:60] is cell 0 (row 0, col 0); row-major; [3:0] is cell 15.
- o_board  out  64  last published board, same layout.
- o_blank_idx  out  4  cell index (0..15) of tile value 4'h0 in o_board.
- o_board_valid  out  1  one-cycle pulse when o_board changes.
- o_reject_cnt  out  8  saturating count of rejected captures (invalid or timed out).

## Operation
- States: S_IDLE, S_START, S_WAIT, S_CHECK, S_COMPARE, S_PUBLISH.
- S_IDLE -> S_START when i_enable = 1.
- S_START: o_capture_start = 1 for this cycle. Clear the timeout counter. Go to S_WAIT.
- S_WAIT on i_capture_done = 1:
  - Latch i_block_order into cap_r.
  - Clear seen[15:0] and dup.
  - Set nibble index k = 0. Go to S_CHECK.
- S_WAIT on timeout counter = TIMEOUT_CYC-1: count a reject, clear stable_cnt, then go to S_START (i_enable = 1) or S_IDLE.
- S_CHECK: one nibble per cycle, k = 0..15; n = cap_r[63-4k -: 4].
  - If seen[n] is already set, set dup.
  - Set seen[n].
  - If n == 0, blank_cand <= k.
  - After k = 15, go to S_COMPARE.
- S_COMPARE, dup = 1: count a reject, clear stable_cnt.
- S_COMPARE, dup = 0:
  - If cap_r == cand_r and stable_cnt != 0: stable_cnt++, saturating at STABLE_COUNT.
  - Otherwise: cand_r <= cap_r, cand_blank <= blank_cand, stable_cnt <= 1.
- Publish condition: updated stable_cnt == STABLE_COUNT, and (cand_r != o_board or nothing published since reset). If met, go to S_PUBLISH. Otherwise go to S_START (i_enable = 1) or S_IDLE.
- S_PUBLISH:
  - o_board <= cand_r; o_blank_idx <= cand_blank; o_board_valid = 1.
  - Set the published flag.
  - Go to S_START or S_IDLE per i_enable.
- A stable board identical to o_board is not republished. stable_cnt is held at saturation.
- o_reject_cnt increments by 1 per reject and holds at 255.
- i_capture_done outside S_WAIT is ignored.
- i_enable falling mid-capture: the current capture completes, including a possible publish, then the block enters S_IDLE. Outputs are retained.

## Timing
- Reset values:
  - All outputs 0: o_board = 64'h0, o_blank_idx = 0, o_board_valid = 0, o_capture_start = 0, o_reject_cnt = 0.
  - State S_IDLE; stable_cnt = 0; published flag = 0.
- All outputs are registered.
- i_enable rises at cycle t: o_capture_start is high at t+1.
- i_capture_done at cycle d, valid capture:
  - S_CHECK occupies d+1..d+16; S_COMPARE is d+17.
  - When publishing: o_board, o_blank_idx and o_board_valid update at d+18, and the next o_capture_start is at d+19.
  - Otherwise the next o_capture_start is at d+18.
- Timeout: o_reject_cnt updates and the restart pulse occurs TIMEOUT_CYC+1 cycles after the o_capture_start pulse.
- Asynchronous reset mid-operation returns everything to reset values immediately. No pulse is emitted on reset release.

## Structure
- Package klotski_pkg holds:
  - state_t (3-bit enum of the six states);
  - BOARD_W = 64, CELLS = 16, TILE_W = 4;
  - BLANK_TILE = 4'h0.
- Sub-module board_perm_check: the 16-cycle nibble walker.
  - Inputs: start, board.
  - Outputs: done, dup, blank_idx.
  - S_CHECK waits on its done.

## Test plan
- i_enable = 1, reader returns 64'h0123456789ABCDEF three times -> one o_board_valid pulse, o_board = 64'h0123456789ABCDEF, o_blank_idx = 0, o_reject_cnt = 0.
- Reader returns 64'h123456789ABCDEF0 ×3 and then keeps returning it -> single publish with o_blank_idx = 15; further captures produce no o_board_valid pulse.
- Reader returns 64'h1123456789ABCDEF -> o_reject_cnt = 1, stable_cnt reset, no publish. The next three 64'h0123456789ABCDEF captures publish.
- Sequence A, A, B, B, B (A = 64'h0123456789ABCDEF, B = 64'h1023456789ABCDEF) -> only B published, with o_blank_idx = 1.
- Reader never asserts done -> reject count 1 and a new o_capture_start TIMEOUT_CYC+1 cycles after the pulse. Repeat 300 times -> o_reject_cnt saturates at 255.
- i_enable dropped during S_CHECK of the third matching capture -> publish still occurs, then S_IDLE with no further starts. Asserting i_rst_n = 0 mid-S_WAIT clears all outputs.
